vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing.sv | 96 +++++++++
 tb/tb_vga_timing.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// VGA raster timing generator clocked by the 25 MHz tap clkdiv[1].
// The counters drive col/row directly. Sync and enable lag one pixel to line up with a registered pixel stage.
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic [31:0] clkdiv,
    input  logic        N_rst,
    output logic [9:0]  col_addr,
    output logic [8:0]  row_addr,
    output logic        fresh,
    output logic        hs,
    output logic        vs,
    output logic        rdn,
    output logic [15:0] frame_cnt
);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + 16);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + 16 + 96 - 1);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + 10);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + 10 + 2 - 1);

    logic       clk_s;
    logic       unused_clkdiv_s;
    logic [9:0] h_cnt_r;
    logic [9:0] v_cnt_r;
    logic [9:0] h_next_s;
    logic [9:0] v_next_s;
    logic       frame_end_s;
    logic       hs_raw_s;
    logic       vs_raw_s;
    logic       en_raw_s;

    // Only bit 1 of the divider bus is a clock; the rest is deliberately ignored.
    assign clk_s           = clkdiv[1];
    assign unused_clkdiv_s = ^{clkdiv[31:2], clkdiv[0]};

    assign col_addr = h_cnt_r;
    assign row_addr = v_cnt_r[8:0];

    // Next counter values; >= keeps both counters in range even if a register is ever upset.
    always_comb begin
        h_next_s    = h_cnt_r + 10'd1;
        v_next_s    = v_cnt_r;
        frame_end_s = 1'b0;
        if (h_cnt_r >= H_LAST) begin
            h_next_s = 10'd0;
            if (v_cnt_r >= V_LAST) begin
                v_next_s    = 10'd0;
                frame_end_s = 1'b1;
            end else begin
                v_next_s = v_cnt_r + 10'd1;
            end
        end else begin
            h_next_s = h_cnt_r + 10'd1;
        end
    end

    // Undelayed sync and display-enable terms decoded from the current counters.
    always_comb begin
        hs_raw_s = !((h_cnt_r >= HS_BEG) && (h_cnt_r <= HS_END));
        vs_raw_s = !((v_cnt_r >= VS_BEG) && (v_cnt_r <= VS_END));
        en_raw_s = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
    end

    // Raster counters, frame-aligned fresh flag, pixel-delayed sync/enable and frame counter.
    always_ff @(posedge clk_s or negedge N_rst) begin
        if (!N_rst) begin
            h_cnt_r   <= 10'd0;
            v_cnt_r   <= 10'd0;
            fresh     <= 1'b1;
            hs        <= 1'b1;
            vs        <= 1'b1;
            rdn       <= 1'b1;
            frame_cnt <= 16'd0;
        end else begin
            h_cnt_r <= h_next_s;
            v_cnt_r <= v_next_s;
            // fresh follows the row the counters move to, so it changes together with row_addr.
            fresh   <= (v_next_s < V_ACT);
            hs      <= hs_raw_s;
            vs      <= vs_raw_s;
            rdn     <= ~en_raw_s;
            if (frame_end_s) begin
                frame_cnt <= frame_cnt + 16'd1;
            end else begin
                frame_cnt <= frame_cnt;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing.sv
// Randomised self-checking bench for vga_timing on a reduced raster (same porches and sync widths).
// The expected outputs come from the edge count since reset, using plain division and modulo.
module tb_vga_timing;
    localparam int HA = 64;
    localparam int HT = 224;
    localparam int VA = 24;
    localparam int VT = 69;
    localparam int FRAME = HT * VT;
    localparam logic [38:0] RST_VEC = {10'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0};

    logic        clk1 = 1'b0;
    logic        clk_en = 1'b1;
    logic [31:0] other_bits = 32'd0;
    logic        N_rst = 1'b0;
    logic [31:0] clkdiv;
    logic [9:0]  col_addr;
    logic [8:0]  row_addr;
    logic        fresh, hs, vs, rdn;
    logic [15:0] frame_cnt;
    logic [38:0] got;

    int          total = 0;
    int          bad = 0;
    int          n = 0;
    logic [15:0] fb = 16'd0;

    assign clkdiv = {other_bits[31:2], clk1, other_bits[0]};
    assign got    = {col_addr, row_addr, fresh, hs, vs, rdn, frame_cnt};

    vga_timing #(.H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT)) dut (
        .clkdiv(clkdiv), .N_rst(N_rst), .col_addr(col_addr), .row_addr(row_addr),
        .fresh(fresh), .hs(hs), .vs(vs), .rdn(rdn), .frame_cnt(frame_cnt)
    );

    always #5 if (clk_en) clk1 = ~clk1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected outputs after n rising edges since reset release, frame counter starting at fb.
    function automatic logic [38:0] model(input int k, input logic [15:0] base);
        int h, v, hp, vp;
        logic fr, h_s, v_s, r_s;
        logic [15:0] f;
        h  = k % HT;
        v  = (k / HT) % VT;
        fr = (v < VA);
        f  = base + 16'(k / FRAME);
        if (k == 0) begin
            h_s = 1'b1; v_s = 1'b1; r_s = 1'b1;
        end else begin
            hp  = (k - 1) % HT;
            vp  = ((k - 1) / HT) % VT;
            h_s = !(hp >= HA + 16 && hp <= HA + 16 + 95);
            v_s = !(vp >= VA + 10 && vp <= VA + 11);
            r_s = !(hp < HA && vp < VA);
        end
        return {10'(h), 9'(v), fr, h_s, v_s, r_s, f};
    endfunction

    task automatic tick(input bit count);
        other_bits = $urandom;
        @(posedge clk1);
        if (count) n++;
        @(negedge clk1);
    endtask

    task automatic test_reset();
        N_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            total++;
            if (got !== RST_VEC) begin
                bad++;
                $display("FAIL reset_hold got=%h want=%h", got, RST_VEC);
            end
        end
        N_rst = 1'b1;
        n = 0;
        fb = 16'd0;
    endtask

    task automatic test_line();
        int first_low = -1;
        int lows = 0;
        for (int i = 0; i < HT; i++) begin
            tick(1'b1);
            total++;
            if (got !== model(n, fb)) begin
                bad++;
                $display("FAIL line n=%0d got=%h want=%h", n, got, model(n, fb));
            end
            if (!hs) begin
                lows++;
                if (first_low < 0) first_low = n;
            end
        end
        total++;
        if (col_addr !== 10'd0 || row_addr !== 9'd1) begin
            bad++;
            $display("FAIL line_wrap col=%0d row=%0d want col=0 row=1", col_addr, row_addr);
        end
        total++;
        if (lows != 96) begin
            bad++;
            $display("FAIL hs_width got=%0d want=96", lows);
        end
        total++;
        if (first_low != HA + 17) begin
            bad++;
            $display("FAIL hs_start got=%0d want=%0d", first_low, HA + 17);
        end
    endtask

    task automatic test_frame();
        int falls = 0;
        int vs_lows = 0;
        int rdn_lows = 0;
        logic prev_fresh;
        logic [15:0] prev_frame;
        prev_fresh = fresh;
        prev_frame = frame_cnt;
        for (int i = 0; i < FRAME; i++) begin
            tick(1'b1);
            total++;
            if (got !== model(n, fb)) begin
                bad++;
                $display("FAIL frame n=%0d got=%h want=%h", n, got, model(n, fb));
            end
            if (!vs) vs_lows++;
            if (!rdn) rdn_lows++;
            if (prev_fresh && !fresh) begin
                falls++;
                total++;
                if (row_addr !== 9'(VA) || col_addr !== 10'd0) begin
                    bad++;
                    $display("FAIL fresh_fall_pos row=%0d col=%0d want row=%0d col=0", row_addr, col_addr, VA);
                end
            end
            if (n == FRAME) begin
                total++;
                if (prev_frame !== 16'd0 || frame_cnt !== 16'd1 || row_addr !== 9'd0) begin
                    bad++;
                    $display("FAIL frame_inc before=%0d after=%0d row=%0d want 0->1 row 0", prev_frame, frame_cnt, row_addr);
                end
            end
            prev_fresh = fresh;
            prev_frame = frame_cnt;
        end
        total++;
        if (falls != 1) begin
            bad++;
            $display("FAIL fresh_falls got=%0d want=1", falls);
        end
        total++;
        if (vs_lows != 2 * HT) begin
            bad++;
            $display("FAIL vs_width got=%0d want=%0d", vs_lows, 2 * HT);
        end
        total++;
        if (rdn_lows != HA * VA) begin
            bad++;
            $display("FAIL rdn_count got=%0d want=%0d", rdn_lows, HA * VA);
        end
    endtask

    task automatic test_other_bits();
        clk_en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            other_bits = $urandom;
            #3;
            total++;
            if (got !== model(n, fb) || clk1 !== 1'b0) begin
                bad++;
                $display("FAIL other_bits i=%0d got=%h want=%h", i, got, model(n, fb));
            end
        end
        clk_en = 1'b1;
    endtask

    task automatic reset_midway(input string tag);
        #($urandom_range(4, 1));
        N_rst = 1'b0;
        #1;
        total++;
        if (got !== RST_VEC) begin
            bad++;
            $display("FAIL %s_async got=%h want=%h", tag, got, RST_VEC);
        end
        tick(1'b0);
        tick(1'b0);
        total++;
        if (got !== RST_VEC) begin
            bad++;
            $display("FAIL %s_held got=%h want=%h", tag, got, RST_VEC);
        end
        N_rst = 1'b1;
        n = 0;
        fb = 16'd0;
        tick(1'b1);
        total++;
        if (col_addr !== 10'd1 || row_addr !== 9'd0 || got !== model(n, fb)) begin
            bad++;
            $display("FAIL %s_restart got=%h want=%h", tag, got, model(n, fb));
        end
    endtask

    task automatic test_midframe_reset();
        int guard = 0;
        while (!((n % HT) == 23 && ((n / HT) % VT) == 10) && guard < FRAME) begin
            tick(1'b1);
            guard++;
        end
        total++;
        if (got !== model(n, fb) || col_addr !== 10'd23 || row_addr !== 9'd10) begin
            bad++;
            $display("FAIL seek_r10_c23 got=%h want=%h", got, model(n, fb));
        end
        reset_midway("midframe");
    endtask

    task automatic test_random_reset();
        for (int r = 0; r < 2; r++) begin
            int target;
            target = $urandom_range(FRAME / 2, 2);
            while (n < target) begin
                tick(1'b1);
                total++;
                if (got !== model(n, fb)) begin
                    bad++;
                    $display("FAIL rand_run n=%0d got=%h want=%h", n, got, model(n, fb));
                end
            end
            reset_midway("rand_reset");
        end
    endtask

    task automatic test_frame_wrap();
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        fb = 16'hFFFF - 16'(n / FRAME);
        total++;
        if (frame_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL preload got=%h want=ffff", frame_cnt);
        end
        while (n < FRAME) begin
            tick(1'b1);
            total++;
            if (got !== model(n, fb)) begin
                bad++;
                $display("FAIL wrap_run n=%0d got=%h want=%h", n, got, model(n, fb));
            end
        end
        total++;
        if (frame_cnt !== 16'h0000) begin
            bad++;
            $display("FAIL frame_wrap got=%h want=0000", frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_other_bits();
        test_midframe_reset();
        test_random_reset();
        test_frame_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
